// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the data/address stimulus generator and its checker.
// Galois next-state functions, seeds, tap masks, popcount and the checker state encoding.
package lfsr_pkg;

    localparam logic [31:0] SEED32 = 32'hFFFF_FFFF;
    localparam logic [9:0]  SEED10 = 10'h3FF;

    // Bit positions receiving the feedback term after the shift (bit 0 takes fb directly).
    localparam logic [31:0] TAPS32 = 32'h0040_0007;
    localparam logic [9:0]  TAPS10 = 10'h009;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lfsr_state_e;

    function automatic logic [31:0] next32(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? TAPS32 : 32'h0);
    endfunction

    function automatic logic [9:0] next10(input logic [9:0] s);
        return {s[8:0], 1'b0} ^ (s[9] ? TAPS10 : 10'h0);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating statistics counter with synchronous clear taking priority over increment.
// Increments of up to 63 per cycle clamp at the all-ones value instead of wrapping.
module lfsr_sat_counter
    import lfsr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [5:0]       inc_val,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nx;

    // One extra bit of headroom detects overflow; any carry out means clamp.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0]       b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        w_count_nx = r_count;
        if (inc_en) begin
            w_count_nx = sat_add(r_count, inc_val);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nx;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the data/address sequences, then
// flags every word that departs from the prediction and keeps saturating statistics.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_MATCHES  = 4,
    parameter int UNLOCK_MISSES = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic [9:0]       in_addr,
    input  logic             clr_stats,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam int MC_W = $clog2(LOCK_MATCHES + 1);
    localparam int MS_W = $clog2(UNLOCK_MISSES + 1);

    lfsr_state_e     r_state;
    lfsr_state_e     w_state_nx;
    logic [31:0]     r_exp_data;
    logic [31:0]     w_exp_data_nx;
    logic [9:0]      r_exp_addr;
    logic [9:0]      w_exp_addr_nx;
    logic [MC_W-1:0] r_match_cnt;
    logic [MC_W-1:0] w_match_cnt_nx;
    logic [MS_W-1:0] r_miss_cnt;
    logic [MS_W-1:0] w_miss_cnt_nx;
    logic            r_locked;
    logic            r_err_pulse;

    logic [31:0]     w_data_xor;
    logic [9:0]      w_addr_xor;
    logic            w_match;
    logic            w_seed_ok;
    logic [5:0]      w_bit_errs;
    logic            w_check;
    logic            w_err;

    assign w_data_xor = in_data ^ r_exp_data;
    assign w_addr_xor = in_addr ^ r_exp_addr;
    assign w_match    = (w_data_xor == 32'h0) && (w_addr_xor == 10'h0);
    // An all-zero field is the LFSR lockup value and can never seed a valid prediction.
    assign w_seed_ok  = (in_data != 32'h0) && (in_addr != 10'h0);
    assign w_bit_errs = popcount(w_data_xor) + popcount({22'h0, w_addr_xor});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= SEARCH;
            r_exp_data  <= 32'h0;
            r_exp_addr  <= 10'h0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_exp_data  <= w_exp_data_nx;
            r_exp_addr  <= w_exp_addr_nx;
            r_match_cnt <= w_match_cnt_nx;
            r_miss_cnt  <= w_miss_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_exp_data_nx  = r_exp_data;
        w_exp_addr_nx  = r_exp_addr;
        w_match_cnt_nx = r_match_cnt;
        w_miss_cnt_nx  = r_miss_cnt;
        if (in_valid) begin
            case (r_state)
                SEARCH: begin
                    if (w_seed_ok) begin
                        w_exp_data_nx  = next32(in_data);
                        w_exp_addr_nx  = next10(in_addr);
                        w_match_cnt_nx = '0;
                        w_state_nx     = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (w_match) begin
                        w_exp_data_nx = next32(r_exp_data);
                        w_exp_addr_nx = next10(r_exp_addr);
                        if (r_match_cnt == MC_W'(LOCK_MATCHES - 1)) begin
                            w_match_cnt_nx = '0;
                            w_miss_cnt_nx  = '0;
                            w_state_nx     = LOCKED;
                        end else begin
                            w_match_cnt_nx = r_match_cnt + MC_W'(1);
                        end
                    end else begin
                        w_match_cnt_nx = '0;
                        if (w_seed_ok) begin
                            w_exp_data_nx = next32(in_data);
                            w_exp_addr_nx = next10(in_addr);
                        end else begin
                            w_state_nx = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    // Once locked, prediction free-runs so corrupted words cannot reseed it.
                    w_exp_data_nx = next32(r_exp_data);
                    w_exp_addr_nx = next10(r_exp_addr);
                    if (w_match) begin
                        w_miss_cnt_nx = '0;
                    end else if (r_miss_cnt == MS_W'(UNLOCK_MISSES - 1)) begin
                        w_miss_cnt_nx = '0;
                        w_state_nx    = SEARCH;
                    end else begin
                        w_miss_cnt_nx = r_miss_cnt + MS_W'(1);
                    end
                end
                default: begin
                    w_state_nx = SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        w_check = in_valid && (r_state == LOCKED);
        w_err   = w_check && !w_match;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_locked    <= (w_state_nx == LOCKED);
            r_err_pulse <= w_err;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr_stats),
        .inc_en  (w_err),
        .inc_val (6'd1),
        .count   (err_count)
    );

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_bit_err_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr_stats),
        .inc_en  (w_err),
        .inc_val (w_bit_errs),
        .count   (bit_err_count)
    );

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr_stats),
        .inc_en  (w_check),
        .inc_val (6'd1),
        .count   (word_count)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a 16-bit-counter instance plus an 8-bit-counter
// instance on the same stream so counter saturation is reachable in few cycles.
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [9:0]  in_addr = 10'h0;
    logic        clr_stats = 1'b0;

    logic        locked, err_pulse;
    logic [15:0] err_count, bit_err_count, word_count;
    logic        locked8, err_pulse8;
    logic [7:0]  err_count8, bit_err_count8, word_count8;

    int checks = 0;
    int errors = 0;

    logic [31:0] g_data;
    logic [9:0]  g_addr;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_MATCHES(4), .UNLOCK_MISSES(3), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
        .clr_stats(clr_stats), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_err_count(bit_err_count), .word_count(word_count)
    );

    lfsr_checker #(.LOCK_MATCHES(4), .UNLOCK_MISSES(3), .CNT_W(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
        .clr_stats(clr_stats), .locked(locked8), .err_pulse(err_pulse8),
        .err_count(err_count8), .bit_err_count(bit_err_count8), .word_count(word_count8)
    );

    // Reference generator, written bit by bit from the Galois description.
    function automatic logic [31:0] ref_next32(input logic [31:0] s);
        logic [31:0] n;
        n[0] = s[31];
        for (int i = 1; i < 32; i++) n[i] = s[i-1];
        n[1]  = n[1]  ^ s[31];
        n[2]  = n[2]  ^ s[31];
        n[22] = n[22] ^ s[31];
        return n;
    endfunction

    function automatic logic [9:0] ref_next10(input logic [9:0] s);
        logic [9:0] n;
        n[0] = s[9];
        for (int i = 1; i < 10; i++) n[i] = s[i-1];
        n[3] = n[3] ^ s[9];
        return n;
    endfunction

    task automatic beat(input logic v, input logic [31:0] d, input logic [9:0] a, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_addr   = a;
        clr_stats = clr;
        @(posedge clk);
        #1;
    endtask

    // Drive the next generator word (optionally corrupted); idle beats carry garbage.
    task automatic gen(input logic v, input logic [31:0] xd, input logic [9:0] xa, input logic clr);
        if (v) begin
            beat(1'b1, g_data ^ xd, g_addr ^ xa, clr);
            g_data = ref_next32(g_data);
            g_addr = ref_next10(g_addr);
        end else begin
            beat(1'b0, $urandom, 10'($urandom), clr);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rstn = 1'b1;
        g_data = 32'hFFFF_FFFF;
        g_addr = 10'h3FF;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0h exp 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0h exp 0", err_pulse); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count got %0h exp 0", err_count); end
        checks++; if (bit_err_count !== 16'h0) begin errors++; $display("FAIL reset_bit_err got %0h exp 0", bit_err_count); end
        checks++; if (word_count !== 16'h0) begin errors++; $display("FAIL reset_word_count got %0h exp 0", word_count); end
        gen(1'b1, 32'h0, 10'h0, 1'b0);
        checks++; if (locked !== 1'b0 || word_count !== 16'h0) begin
            errors++; $display("FAIL reset_first_beat got locked=%0h words=%0h exp 0/0", locked, word_count);
        end
    endtask

    task automatic test_clean_lock();
        int pulses;
        do_reset();
        checks++; if (g_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL gen_seed got %h exp ffffffff", g_data); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                checks++; if (g_data !== 32'hFFBF_FFF9 || g_addr !== 10'h3F7) begin
                    errors++; $display("FAIL gen_word1 got %h/%h exp ffbffff9/3f7", g_data, g_addr);
                end
            end
            gen(1'b1, 32'h0, 10'h0, 1'b0);
            checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL lock_beat%0d got %0h exp %0h", i, locked, (i == 4)); end
        end
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            gen(1'b1, 32'h0, 10'h0, 1'b0);
            if (err_pulse !== 1'b0 || locked !== 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL clean_pulses got %0d exp 0", pulses); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d exp 0", err_count); end
        checks++; if (bit_err_count !== 16'd0) begin errors++; $display("FAIL clean_bit_err got %0d exp 0", bit_err_count); end
        checks++; if (word_count !== 16'd1000) begin errors++; $display("FAIL clean_word_count got %0d exp 1000", word_count); end
    endtask

    task automatic test_single_flip();
        gen(1'b1, 32'h0000_0080, 10'h0, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL flip_pulse got %0h exp 1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL flip_err_count got %0d exp 1", err_count); end
        checks++; if (bit_err_count !== 16'd1) begin errors++; $display("FAIL flip_bit_err got %0d exp 1", bit_err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL flip_locked got %0h exp 1", locked); end
        checks++; if (word_count !== 16'd1001) begin errors++; $display("FAIL flip_word_count got %0d exp 1001", word_count); end
        gen(1'b1, 32'h0, 10'h0, 1'b0);
        checks++; if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL flip_after got pulse=%0h errs=%0d lock=%0h exp 0/1/1", err_pulse, err_count, locked);
        end
    endtask

    task automatic test_unlock_relock();
        gen(1'b0, 32'h0, 10'h0, 1'b1);
        checks++; if (err_count !== 16'd0 || bit_err_count !== 16'd0 || word_count !== 16'd0) begin
            errors++; $display("FAIL idle_clear got %0d/%0d/%0d exp 0/0/0", err_count, bit_err_count, word_count);
        end
        for (int i = 0; i < 3; i++) begin
            gen(1'b1, 32'h0001_0001, 10'h200, 1'b0);
            checks++; if (err_pulse !== 1'b1 || locked !== (i < 2)) begin
                errors++; $display("FAIL miss%0d got pulse=%0h lock=%0h exp 1/%0h", i, err_pulse, locked, (i < 2));
            end
        end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL miss_err_count got %0d exp 3", err_count); end
        checks++; if (bit_err_count !== 16'd9) begin errors++; $display("FAIL miss_bit_err got %0d exp 9", bit_err_count); end
        checks++; if (word_count !== 16'd3) begin errors++; $display("FAIL miss_word_count got %0d exp 3", word_count); end
        for (int i = 0; i < 5; i++) begin
            gen(1'b1, 32'h0, 10'h0, 1'b0);
            checks++; if (locked !== (i == 4) || err_pulse !== 1'b0) begin
                errors++; $display("FAIL relock%0d got lock=%0h pulse=%0h exp %0h/0", i, locked, err_pulse, (i == 4));
            end
        end
        checks++; if (err_count !== 16'd3 || word_count !== 16'd3) begin
            errors++; $display("FAIL relock_counts got %0d/%0d exp 3/3", err_count, word_count);
        end
    endtask

    task automatic test_zero_word();
        do_reset();
        beat(1'b1, 32'h0, 10'h2AB, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_data got lock=%0h exp 0", locked); end
        beat(1'b1, 32'h1234_5678, 10'h0, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_addr got lock=%0h exp 0", locked); end
        for (int i = 0; i < 5; i++) begin
            gen(1'b1, 32'h0, 10'h0, 1'b0);
            checks++; if (locked !== (i == 4)) begin errors++; $display("FAIL zero_lock%0d got %0h exp %0h", i, locked, (i == 4)); end
        end
        checks++; if (word_count !== 16'd0 || err_count !== 16'd0) begin
            errors++; $display("FAIL zero_counts got %0d/%0d exp 0/0", word_count, err_count);
        end
    endtask

    task automatic test_gaps();
        int nv, nbeats, lock_at, pulses;
        logic v, was_locked;
        do_reset();
        nv = 0; nbeats = 0; lock_at = -1; pulses = 0;
        for (int i = 0; i < 300; i++) begin
            v = 1'($urandom_range(0, 1));
            was_locked = locked;
            gen(v, 32'h0, 10'h0, 1'b0);
            if (v) nbeats++;
            if (v && was_locked) nv++;
            if (locked && lock_at < 0) lock_at = nbeats;
            if (err_pulse) pulses++;
        end
        checks++; if (lock_at != 5) begin errors++; $display("FAIL gaps_lock_beat got %0d exp 5", lock_at); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gaps_locked got %0h exp 1", locked); end
        checks++; if (pulses != 0 || err_count !== 16'd0) begin
            errors++; $display("FAIL gaps_errors got %0d/%0d exp 0/0", pulses, err_count);
        end
        checks++; if (word_count !== 16'(nv)) begin errors++; $display("FAIL gaps_word_count got %0d exp %0d", word_count, nv); end
    endtask

    task automatic test_clr_collision();
        gen(1'b1, 32'h0000_00F0, 10'h0, 1'b1);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %0h exp 1", err_pulse); end
        checks++; if (err_count !== 16'd0 || bit_err_count !== 16'd0 || word_count !== 16'd0) begin
            errors++; $display("FAIL clr_counts got %0d/%0d/%0d exp 0/0/0", err_count, bit_err_count, word_count);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %0h exp 1", locked); end
        gen(1'b1, 32'h0, 10'h0, 1'b0);
        checks++; if (word_count !== 16'd1 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
            errors++; $display("FAIL clr_after got %0d/%0d/%0h exp 1/0/0", word_count, err_count, err_pulse);
        end
    endtask

    task automatic test_saturation();
        gen(1'b0, 32'h0, 10'h0, 1'b1);
        for (int i = 0; i < 127; i++) begin
            gen(1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b0);
            gen(1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b0);
            gen(1'b1, 32'h0, 10'h0, 1'b0);
        end
        checks++; if (err_count8 !== 8'hFE) begin errors++; $display("FAIL sat8_pre got %0h exp fe", err_count8); end
        checks++; if (err_count !== 16'd254) begin errors++; $display("FAIL sat16_pre_errs got %0d exp 254", err_count); end
        checks++; if (bit_err_count !== 16'd10668) begin errors++; $display("FAIL sat16_pre_bits got %0d exp 10668", bit_err_count); end
        checks++; if (word_count8 !== 8'hFF || bit_err_count8 !== 8'hFF) begin
            errors++; $display("FAIL sat8_words_bits got %0h/%0h exp ff/ff", word_count8, bit_err_count8);
        end
        for (int i = 0; i < 3; i++) begin
            gen(1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b0);
            gen(1'b1, 32'h0, 10'h0, 1'b0);
        end
        checks++; if (err_count8 !== 8'hFF) begin errors++; $display("FAIL sat8_hold got %0h exp ff", err_count8); end
        checks++; if (err_count !== 16'd257) begin errors++; $display("FAIL sat16_errs got %0d exp 257", err_count); end
        for (int i = 0; i < 1400; i++) begin
            gen(1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b0);
            gen(1'b1, 32'hFFFF_FFFF, 10'h3FF, 1'b0);
            gen(1'b1, 32'h0, 10'h0, 1'b0);
        end
        checks++; if (bit_err_count !== 16'hFFFF) begin errors++; $display("FAIL sat16_bits got %0h exp ffff", bit_err_count); end
        checks++; if (err_count !== 16'd3057) begin errors++; $display("FAIL bulk_errs got %0d exp 3057", err_count); end
        checks++; if (word_count !== 16'd4587) begin errors++; $display("FAIL bulk_words got %0d exp 4587", word_count); end
        checks++; if (err_count8 !== 8'hFF) begin errors++; $display("FAIL sat8_final got %0h exp ff", err_count8); end
        checks++; if (locked !== 1'b1 || locked8 !== 1'b1) begin
            errors++; $display("FAIL sat_locked got %0h/%0h exp 1/1", locked, locked8);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_unlock_relock();
        test_zero_word();
        test_gaps();
        test_clr_collision();
        test_saturation();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the data/address LFSR stimulus generator. Consumes a stream of 32-bit data and 10-bit address words, self-synchronises a local copy of both LFSR sequences, and then checks every subsequent word against its prediction. Reports lock status, per-word error pulses and saturating error and traffic statistics for memory and interconnect soak tests.

## Interface
Parameters:
- LOCK_MATCHES, 4: consecutive matching words in ACQUIRE needed to declare lock (≥1).
- UNLOCK_MISSES, 3: consecutive mismatching words in LOCKED needed to drop lock (≥1).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  word present this cycle.
- in_data  in  32  received data word.
- in_addr  in  10  received address word.
- clr_stats  in  1  synchronous clear of the statistics counters.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word in LOCKED.
- err_count  out  CNT_W  mismatching words, saturating.
- bit_err_count  out  CNT_W  total flipped bits (data+addr), saturating.
- word_count  out  CNT_W  words checked in LOCKED, saturating.

## Operation
- Next-state functions, identical to the generator's Galois forms. Each returns the shifted word with these taps XORed with fb:
  - next32: fb = s[31]; s'[0] = fb; s'[1] = s[0]^fb; s'[2] = s[1]^fb; s'[22] = s[21]^fb; every other bit s'[i] = s[i-1].
  - next10: fb = s[9]; s'[0] = fb; s'[3] = s[2]^fb; every other bit s'[i] = s[i-1].
- States: SEARCH (reset state), ACQUIRE, LOCKED. Only beats with in_valid=1 cause any state or counter update.
- SEARCH, valid beat:
  - If in_data==0 or in_addr==0 (LFSR lockup value), ignore the beat.
  - Otherwise set exp_data = next32(in_data), exp_addr = next10(in_addr), match_cnt = 0, go to ACQUIRE.
- ACQUIRE, valid beat:
  - Match (both fields equal their expected values): advance exp by one step and increment match_cnt. On the LOCK_MATCHES-th match, go to LOCKED with miss_cnt = 0.
  - Mismatch: reseed exp from the received word (as in SEARCH; a zero field sends the block back to SEARCH) and set match_cnt = 0.
- LOCKED, valid beat:
  - exp always advances from exp, never from the received word. word_count += 1.
  - Match: miss_cnt = 0.
  - Mismatch: err_pulse is asserted, err_count += 1, bit_err_count += popcount(in_data^exp_data) + popcount(in_addr^exp_addr) (sum is 0..42), miss_cnt += 1. On the UNLOCK_MISSES-th consecutive miss, go to SEARCH.
- All counters saturate at 2^CNT_W−1 and never wrap. A saturating add clamps.
- clr_stats zeroes err_count, bit_err_count and word_count. Clear has priority: a beat checked in the same cycle is not counted. clr_stats does not affect state, exp, match_cnt or miss_cnt.
- Reset (at any time, including mid-sequence): state = SEARCH; exp, match_cnt and miss_cnt = 0; all outputs 0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- A beat sampled at edge N produces its results at edge N: locked, err_pulse and the counters reflect that beat in the cycle after edge N.
- err_pulse lasts exactly one cycle per mismatching beat. It is high on back-to-back cycles for back-to-back mismatches.
- locked rises in the cycle after the LOCK_MATCHES-th matching beat. It falls in the cycle after the UNLOCK_MISSES-th consecutive miss; that final missing beat still pulses err_pulse and is counted.
- in_valid may be deasserted for any number of cycles. Gaps never affect prediction or state.
- No backpressure: the block accepts one word per cycle.

## Structure
- Package lfsr_pkg holds:
  - Seed constants: SEED32 = 32'hFFFFFFFF, SEED10 = 10'h3FF.
  - Tap positions.
  - Functions next32/next10.
  - A popcount function.
  - The state enum (SEARCH/ACQUIRE/LOCKED).
- The generator also uses lfsr_pkg.
- One sub-module, lfsr_sat_counter (parameter CNT_W; inputs clr, inc_en, inc_val[5:0]), is instantiated three times for the statistics.
- The FSM, expected-value registers and compare logic live in lfsr_checker.

## Test plan
- Clean stream from the generator seeded 0xFFFFFFFF/0x3FF, first words 0xFFFFFFFF/0x3FF then 0xFFBFFFF9/0x3F7: locked rises after the 5th valid word; 1000 further words leave err_count=0 and word_count=1000.
- Locked stream, one word with data bit 7 flipped: a single err_pulse, err_count=1, bit_err_count=1, locked stays 1, following words match.
- Three consecutive corrupted words (UNLOCK_MISSES=3): three pulses, err_count=3; locked falls after the third word, then re-locks after 5 clean words with no further count increase.
- First word in_data=0 with valid addr: ignored, state stays SEARCH; the next non-zero word seeds and lock follows 4 matches later.
- in_valid toggled 1-0-1 randomly on a clean stream: locked reached, zero errors, word_count equals the number of valid beats since lock.
- Locked, clr_stats asserted in the same cycle as a mismatching word: all counters read 0 the next cycle and err_pulse=1. Also force err_count to 0xFFFE, inject 3 errors: the counter holds at 0xFFFF.
